// File: rtl/pipeline_sequencer_if.sv
// Control/status bundle between the sequencer (slave) and whatever drives its requests (master).
interface pipeline_sequencer_if;
    logic       start_i;
    logic       stop_i;
    logic       locked_i;
    logic       cap_en_o;
    logic       acq_en_o;
    logic       cor_en_o;
    logic       ready_o;
    logic       fault_o;
    logic [2:0] state_o;

    modport master (
        output start_i, stop_i, locked_i,
        input  cap_en_o, acq_en_o, cor_en_o, ready_o, fault_o, state_o
    );

    modport slave (
        input  start_i, stop_i, locked_i,
        output cap_en_o, acq_en_o, cor_en_o, ready_o, fault_o, state_o
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Brings capture, acquisition and correlator stages up in order and down in reverse.
// Optional PLL lock monitor: define TART_LOCK_MONITOR_EN.
module pipeline_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CAP_TO_ACQ    = 8,
    parameter int unsigned ACQ_TO_COR    = 8,
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned CW            = 8
) (
    input logic                 clock,
    input logic                 reset,
    pipeline_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        ACQUIRE = 3'd3,
        RUN     = 3'd4,
        DRAIN   = 3'd5
    } state_e;

    // Counters hold gap-1 so a state lasts exactly its parameter in cycles.
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CAP_LD    = CW'(CAP_TO_ACQ - 1);
    localparam logic [CW-1:0] ACQ_LD    = CW'(ACQ_TO_COR - 1);
    localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cap_q, acq_q, cor_q, rdy_q;
    logic          lock_ok, lock_lost;
    logic          fault_q, fault_d;

`ifdef TART_LOCK_MONITOR_EN
    assign lock_ok   = bus.locked_i;
    assign lock_lost = (state_q != IDLE) && !bus.locked_i;
`else
    logic unused_locked;
    assign unused_locked = bus.locked_i;
    assign lock_ok       = 1'b1;
    assign lock_lost     = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.stop_i && lock_ok) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                    fault_d = 1'b0;
                end
            end
            SETTLE, CAPTURE, ACQUIRE: begin
                if (bus.stop_i) begin
                    state_d = cap_q ? DRAIN : IDLE;
                    cnt_d   = cap_q ? DRAIN_LD : '0;
                end else if (cnt_q == '0) begin
                    state_d = (state_q == SETTLE)  ? CAPTURE :
                              (state_q == CAPTURE) ? ACQUIRE : RUN;
                    cnt_d   = (state_q == SETTLE)  ? CAP_LD :
                              (state_q == CAPTURE) ? ACQ_LD : '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (bus.stop_i) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LD;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (lock_lost) begin
            state_d = IDLE;
            cnt_d   = '0;
            fault_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            acq_q   <= 1'b0;
            cor_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= state_d inside {CAPTURE, ACQUIRE, RUN, DRAIN};
            acq_q   <= state_d inside {ACQUIRE, RUN};
            cor_q   <= (state_d == RUN);
            rdy_q   <= (state_d == RUN);
        end
    end

`ifdef TART_LOCK_MONITOR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end
`else
    assign fault_q = 1'b0;
    logic unused_fault_d;
    assign unused_fault_d = fault_d;
`endif

    assign bus.cap_en_o = cap_q;
    assign bus.acq_en_o = acq_q;
    assign bus.cor_en_o = cor_q;
    assign bus.ready_o  = rdy_q;
    assign bus.fault_o  = fault_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed plus randomized bench for pipeline_sequencer against an edge-timeline reference model.
// Define TART_LOCK_MONITOR_EN to also exercise the lock monitor.
module tb_pipeline_sequencer;

    localparam int SETTLE = 16;
    localparam int C2A    = 8;
    localparam int A2C    = 8;
    localparam int DRAIN  = 4;

`ifdef TART_LOCK_MONITOR_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_sequencer_if bus ();

    pipeline_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Model: mode 0 idle, 1 sequencing up since edge m_k, 2 draining until edge m_d.
    int   m_mode  = 0;
    int   m_k     = 0;
    int   m_d     = 0;
    logic m_fault = 1'b0;

    int   cap_rise = -1, acq_rise = -1, cor_rise = -1, cap_fall = -1, cor_fall = -1;
    logic prev_cap = 1'b0, prev_acq = 1'b0, prev_cor = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {bus.cap_en_o, bus.acq_en_o, bus.cor_en_o, bus.ready_o, bus.fault_o, bus.state_o};
    endfunction

    function automatic logic [7:0] exp_vec();
        int e;
        logic cap, acq, cor;
        logic [2:0] st;
        cap = 1'b0; acq = 1'b0; cor = 1'b0; st = 3'd0;
        if (m_mode == 2) begin
            cap = 1'b1; st = 3'd5;
        end else if (m_mode == 1) begin
            e   = edge_n - m_k;
            cap = (e >= SETTLE);
            acq = (e >= SETTLE + C2A);
            cor = (e >= SETTLE + C2A + A2C);
            st  = cor ? 3'd4 : acq ? 3'd3 : cap ? 3'd2 : 3'd1;
        end
        return {cap, acq, cor, cor, m_fault, st};
    endfunction

    task automatic model_update(input logic st, input logic sp, input logic lk);
        logic cap_now;
        cap_now = (m_mode == 2) || (m_mode == 1 && (edge_n - 1 - m_k) >= SETTLE);
        if (LOCK_EN && m_mode != 0 && !lk) begin
            m_mode  = 0;
            m_fault = 1'b1;
        end else if (m_mode == 0) begin
            if (st && !sp && (!LOCK_EN || lk)) begin
                m_mode  = 1;
                m_k     = edge_n;
                m_fault = 1'b0;
            end
        end else if (m_mode == 1) begin
            if (sp) begin
                if (cap_now) begin
                    m_mode = 2;
                    m_d    = edge_n + DRAIN;
                end else begin
                    m_mode = 0;
                end
            end
        end else if (edge_n >= m_d) begin
            m_mode = 0;
        end
    endtask

    task automatic step(input logic st, input logic sp, input logic lk, input string tag);
        @(negedge clock);
        bus.start_i  = st;
        bus.stop_i   = sp;
        bus.locked_i = lk;
        @(posedge clock);
        edge_n++;
        model_update(st, sp, lk);
        #1;
        check(tag, {24'd0, dut_vec()}, {24'd0, exp_vec()});
        if (bus.cap_en_o && !prev_cap && cap_rise < 0) cap_rise = edge_n;
        if (bus.acq_en_o && !prev_acq && acq_rise < 0) acq_rise = edge_n;
        if (bus.cor_en_o && !prev_cor && cor_rise < 0) cor_rise = edge_n;
        if (!bus.cap_en_o && prev_cap && cap_fall < 0) cap_fall = edge_n;
        if (!bus.cor_en_o && prev_cor && cor_fall < 0) cor_fall = edge_n;
        prev_cap = bus.cap_en_o;
        prev_acq = bus.acq_en_o;
        prev_cor = bus.cor_en_o;
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.stop_i   = 1'b0;
        bus.locked_i = 1'b1;
        #12;
        check("reset_state", {24'd0, dut_vec()}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Bring-up from reset: start sampled on edge 10.
        idle_steps(9, "pre_start");
        step(1'b1, 1'b0, 1'b1, "start_edge10");
        idle_steps(34, "bringup");
        step(1'b1, 1'b0, 1'b1, "start_in_run");
        idle_steps(4, "run_hold");
        check("run_state", {29'd0, bus.state_o}, 32'd4);
        check("cap_rise_edge", cap_rise, 32'd26);
        check("acq_rise_edge", acq_rise, 32'd34);
        check("cor_rise_edge", cor_rise, 32'd42);

        // Stop in RUN on edge 50, restart on edge 55.
        step(1'b0, 1'b1, 1'b1, "stop_in_run");
        check("cor_fall_edge", cor_fall, 32'd50);
        idle_steps(4, "drain");
        check("cap_fall_edge", cap_fall, 32'd54);
        check("idle_after_drain", {29'd0, bus.state_o}, 32'd0);
        step(1'b1, 1'b0, 1'b1, "restart_edge55");
        check("restart_settle", {29'd0, bus.state_o}, 32'd1);

        // Stop while still settling: straight to IDLE.
        idle_steps(3, "settle");
        step(1'b0, 1'b1, 1'b1, "stop_in_settle");
        check("settle_stop_idle", {24'd0, dut_vec()}, 32'd0);

        // Stop in ACQUIRE: four drain cycles with capture held.
        step(1'b1, 1'b0, 1'b1, "start_b");
        idle_steps(SETTLE + C2A + 2, "to_acquire");
        step(1'b0, 1'b1, 1'b1, "stop_in_acquire");
        check("acq_stop_drain", {29'd0, bus.state_o}, 32'd5);
        idle_steps(DRAIN, "acq_drain");

        // Simultaneous start and stop in IDLE, then stop alone in IDLE.
        step(1'b1, 1'b1, 1'b1, "start_stop_idle");
        step(1'b0, 1'b1, 1'b1, "stop_idle");

        // Asynchronous reset mid-CAPTURE.
        step(1'b1, 1'b0, 1'b1, "start_c");
        idle_steps(SETTLE + 2, "to_capture");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {24'd0, dut_vec()}, 32'd0);
        m_mode  = 0;
        m_fault = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        idle_steps(2, "post_reset");

`ifdef TART_LOCK_MONITOR_EN
        step(1'b1, 1'b0, 1'b1, "start_lock");
        idle_steps(SETTLE + C2A + A2C + 2, "to_run_lock");
        step(1'b0, 1'b0, 1'b0, "lock_drop");
        check("lock_fault", {31'd0, bus.fault_o}, 32'd1);
        step(1'b1, 1'b0, 1'b0, "start_unlocked");
        check("unlocked_start_ignored", {29'd0, bus.state_o}, 32'd0);
        step(1'b0, 1'b0, 1'b1, "relock");
        step(1'b1, 1'b0, 1'b1, "start_relocked");
        check("fault_cleared", {31'd0, bus.fault_o}, 32'd0);
        idle_steps(4, "relocked_settle");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 149) != 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequences the enables of the capture, acquisition and correlator stages once the clock-and-reset stage has released `reset` on the system `clock`. It sits directly downstream of clock/reset generation and upstream of the datapath. On a start request it brings the stages up in a fixed order with programmable settle gaps. On a stop request it brings them down in reverse order, and when the optional lock monitor is compiled in it also handles PLL lock loss.

## Interface
- `SETTLE_CYCLES`, 16: cycles in SETTLE before capture is enabled.
- `CAP_TO_ACQ`, 8: cycles from `cap_en` rising to `acq_en` rising.
- `ACQ_TO_COR`, 8: cycles from `acq_en` rising to `cor_en` rising.
- `DRAIN_CYCLES`, 4: cycles `cap_en` is held after `cor_en` and `acq_en` drop.
- `CW`, 8: width of the gap counter. Every gap parameter must be in the range 1 to 2**CW-1.

- `clock` in 1: system clock; the single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock indication. Used only with the lock monitor compiled in.
- `start` in 1: single-cycle start request.
- `stop` in 1: single-cycle stop request.
- `cap_en` out 1: capture stage enable.
- `acq_en` out 1: acquisition stage enable.
- `cor_en` out 1: correlator enable.
- `ready` out 1: high only in RUN.
- `fault` out 1: sticky lock-loss flag.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings:
  - IDLE = 0
  - SETTLE = 1
  - CAPTURE = 2
  - ACQUIRE = 3
  - RUN = 4
  - DRAIN = 5
  - Codes 6 and 7 go to IDLE on the next edge.
- Gap counter: loaded with the state's gap parameter minus 1 on entry to a timed state; decrements each cycle; the state exits when the counter is 0 and decrements. Each timed state therefore lasts exactly its parameter in cycles.
- Transitions:
  - IDLE to SETTLE when `start` is high (gated by lock, see Configuration). Entering SETTLE clears `fault`.
  - SETTLE to CAPTURE after `SETTLE_CYCLES`.
  - CAPTURE to ACQUIRE after `CAP_TO_ACQ`.
  - ACQUIRE to RUN after `ACQ_TO_COR`.
  - RUN to DRAIN when `stop` is high.
  - DRAIN to IDLE after `DRAIN_CYCLES`.
- `stop` in SETTLE, CAPTURE or ACQUIRE: go to DRAIN if `cap_en` is currently high, otherwise to IDLE.
- Output decode per state (registered, changing on the same edge as `state`):
  - `cap_en` is high in CAPTURE, ACQUIRE, RUN and DRAIN.
  - `acq_en` is high in ACQUIRE and RUN.
  - `cor_en` is high in RUN.
- Simultaneous `start` and `stop`: `stop` wins. `start` outside IDLE is ignored. `stop` in IDLE is ignored.
- Asserting `reset` mid-sequence forces IDLE immediately.

## Timing
- Reset values: `cap_en`, `acq_en`, `cor_en`, `ready` and `fault` are all 0; `state` is 0; the counter is 0.
- All outputs are registered with no combinational path from any input to any output.
- Measured from the edge sampling `start` (edge k):
  - `cap_en` rises at k+`SETTLE_CYCLES`.
  - `acq_en` rises at k+`SETTLE_CYCLES`+`CAP_TO_ACQ`.
  - `cor_en` and `ready` rise at k+`SETTLE_CYCLES`+`CAP_TO_ACQ`+`ACQ_TO_COR`.
- Measured from the edge sampling `stop` in RUN (edge s):
  - `cor_en`, `acq_en` and `ready` fall at s.
  - `cap_en` falls at s+`DRAIN_CYCLES`.
  - `start` is accepted again from edge s+`DRAIN_CYCLES`+1.

## Configuration
- Macro `TART_LOCK_MONITOR_EN`.
- Defined:
  - `start` is accepted only while `locked` is high.
  - `locked` sampled low in any state other than IDLE sends the block to IDLE at that edge, with all enables low and `fault` set to 1.
  - `fault` stays high until the next accepted `start`.
- Undefined: `locked` is ignored and `fault` is tied to 0.

## Test plan
- Defaults: reset release, then `start` at edge 10 -> `cap_en` at 26, `acq_en` at 34, `cor_en` and `ready` at 42, `state` = 4.
- `stop` at edge 50 in RUN -> `cor_en` and `acq_en` low at 50, `cap_en` low at 54, `state` = 0 at 54; a `start` at 55 is accepted.
- `stop` in SETTLE (before `cap_en`) -> IDLE next edge with all enables 0; `stop` in ACQUIRE -> DRAIN for 4 cycles, then IDLE.
- `start` and `stop` asserted together in IDLE -> stays in IDLE; `start` pulsed during RUN -> no change in outputs.
- `reset` asserted asynchronously mid-CAPTURE -> all outputs 0 and `state` = 0 without waiting for a clock edge.
- With `TART_LOCK_MONITOR_EN`:
  - `locked` dropped in RUN -> IDLE with `fault` = 1.
  - `start` while `locked` = 0 -> ignored.
  - `locked` = 1 then `start` -> `fault` clears and the sequence restarts.
